irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 13 +
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 93 +++++++++
 tb/tb_irq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map and sizing constants for irq_ctrl
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_PEND  = 3'd0;
    localparam logic [2:0] IRQ_EN    = 3'd1;
    localparam logic [2:0] IRQ_TRIG  = 3'd2;
    localparam logic [2:0] IRQ_CTRL  = 3'd3;
    localparam logic [2:0] IRQ_CLAIM = 3'd4;

    localparam int IRQ_MAX_NSRC = 31;
    localparam int IRQ_ID_W     = 6;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = IRQ_ID_W
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scanning downward lets the lowest set index be the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller with pending/enable/trigger/claim registers
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] i_src,
    input  logic [2:0]      i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    input  logic            i_wb_we,
    input  logic            i_wb_cyc,
    output logic [31:0]     o_wb_rdt,
    output logic            o_wb_ack,
    output logic            o_irq
);

    logic [NSRC-1:0]     pend, en, trig, src_q;
    logic                gie;
    logic [NSRC-1:0]     act, set_vec, clr_vec, claim_mask;
    logic                claim_vld, wr_ack, claim_rd;
    logic [IRQ_ID_W-1:0] claim_idx, claim_id;
    logic                unused_dat;

    assign unused_dat = &{1'b0, i_wb_dat[31:NSRC]};

    assign act = pend & en;

    irq_prio_enc #(
        .N  (NSRC),
        .IW (IRQ_ID_W)
    ) u_prio (
        .req   (act),
        .valid (claim_vld),
        .idx   (claim_idx)
    );

    assign claim_id = claim_vld ? claim_idx + IRQ_ID_W'(1) : '0;
    assign wr_ack   = o_wb_ack & i_wb_we;
    assign claim_rd = o_wb_ack & ~i_wb_we & (i_wb_adr == IRQ_CLAIM) & claim_vld;

    // Edge sources need a fresh rise; level sources re-pend while high.
    assign set_vec = i_src & (~trig | ~src_q);

    always_comb begin
        claim_mask = '0;
        for (int k = 0; k < NSRC; k++) begin
            claim_mask[k] = claim_rd && (claim_idx == IRQ_ID_W'(k));
        end
    end

    assign clr_vec = claim_mask |
                     ((wr_ack && (i_wb_adr == IRQ_PEND)) ? i_wb_dat[NSRC-1:0] : '0);

    always_comb begin
        o_wb_rdt = '0;
        case (i_wb_adr)
            IRQ_PEND:  o_wb_rdt = 32'(pend);
            IRQ_EN:    o_wb_rdt = 32'(en);
            IRQ_TRIG:  o_wb_rdt = 32'(trig);
            IRQ_CTRL:  o_wb_rdt = {31'b0, gie};
            IRQ_CLAIM: o_wb_rdt = 32'(claim_id);
            default:   o_wb_rdt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            en       <= '0;
            trig     <= '1;
            gie      <= 1'b0;
            src_q    <= '0;
            o_irq    <= 1'b0;
            o_wb_ack <= 1'b0;
        end else begin
            src_q    <= i_src;
            pend     <= (pend & ~clr_vec) | set_vec;
            o_irq    <= gie & (|act);
            o_wb_ack <= i_wb_cyc & ~o_wb_ack;
            if (wr_ack) begin
                case (i_wb_adr)
                    IRQ_EN:   en   <= i_wb_dat[NSRC-1:0];
                    IRQ_TRIG: trig <= i_wb_dat[NSRC-1:0];
                    IRQ_CTRL: gie  <= i_wb_dat[0];
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - randomized and directed bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSRC-1:0] src;
    logic [2:0]      adr;
    logic [31:0]     dat;
    logic            we, cyc;
    logic [31:0]     rdt;
    logic            ack, irq;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_src    (src),
        .i_wb_adr (adr),
        .i_wb_dat (dat),
        .i_wb_we  (we),
        .i_wb_cyc (cyc),
        .o_wb_rdt (rdt),
        .o_wb_ack (ack),
        .o_irq    (irq)
    );

    int total = 0;
    int bad   = 0;

    logic [NSRC-1:0] m_pend, m_en, m_trig, m_srcq;
    logic            m_gie, m_irq, m_ack;
    logic [31:0]     last_rdt;
    logic [31:0]     d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_claim();
        for (int k = 0; k < NSRC; k++)
            if (m_pend[k] && m_en[k]) return k + 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            IRQ_PEND:  return 32'(m_pend);
            IRQ_EN:    return 32'(m_en);
            IRQ_TRIG:  return 32'(m_trig);
            IRQ_CTRL:  return {31'b0, m_gie};
            IRQ_CLAIM: return 32'(model_claim());
            default:   return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_trig = '1; m_srcq = '0;
        m_gie = 1'b0; m_irq = 1'b0; m_ack = 1'b0;
    endtask

    // One clock cycle: check read data, predict the next state, clock, compare outputs.
    task automatic tick();
        logic [NSRC-1:0] np, ne, nt;
        logic            ng, ni, na;
        int              id;
        #1;
        chk("rdt", rdt, model_read(adr));
        if (m_ack) last_rdt = rdt;
        np = m_pend; ne = m_en; nt = m_trig; ng = m_gie;
        if (m_ack && we) begin
            case (adr)
                IRQ_PEND: np = np & ~dat[NSRC-1:0];
                IRQ_EN:   ne = dat[NSRC-1:0];
                IRQ_TRIG: nt = dat[NSRC-1:0];
                IRQ_CTRL: ng = dat[0];
                default:  ;
            endcase
        end
        if (m_ack && !we && adr == IRQ_CLAIM) begin
            id = model_claim();
            if (id != 0) np[id-1] = 1'b0;
        end
        for (int k = 0; k < NSRC; k++) begin
            if (m_trig[k] ? (src[k] && !m_srcq[k]) : src[k]) np[k] = 1'b1;
        end
        ni = m_gie && ((m_pend & m_en) != '0);
        na = cyc && !m_ack;
        @(posedge clk);
        #1;
        m_pend = np; m_en = ne; m_trig = nt; m_gie = ng;
        m_irq = ni; m_ack = na; m_srcq = src;
        chk("ack", ack, m_ack);
        chk("irq", irq, m_irq);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] v);
        cyc = 1'b1; we = 1'b0; adr = a;
        tick();
        tick();
        v = last_rdt;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] v);
        cyc = 1'b1; we = 1'b1; adr = a; dat = v;
        tick();
        tick();
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; we = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [31:0] reset_exp [5];
        reset_exp = '{32'h0, 32'h0, 32'hFF, 32'h0, 32'h0};
        rst_n = 1'b0; src = '0; adr = '0; dat = '0; we = 1'b0; cyc = 1'b0;
        last_rdt = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset/idle with continuous cyc
        chk("rst_irq", irq, 0);
        chk("rst_ack", ack, 0);
        cyc = 1'b1; adr = IRQ_PEND;
        tick();
        chk("ack_hi", ack, 1);
        tick();
        chk("ack_lo", ack, 0);
        for (int a = 0; a < 5; a++) begin
            wb_read(3'(a), d);
            chk("rst_reg", d, reset_exp[a]);
        end
        idle(2);

        // Timer pulse on source 0
        wb_write(IRQ_EN, 32'h1);
        wb_write(IRQ_CTRL, 32'h1);
        idle(2);
        src = 8'h01;
        tick();
        src = 8'h00;
        chk("timer_irq_n1", irq, 0);
        tick();
        chk("timer_irq_n2", irq, 1);
        wb_read(IRQ_PEND, d);  chk("timer_pend", d, 32'h01);
        wb_read(IRQ_CLAIM, d); chk("timer_claim", d, 32'd1);
        wb_read(IRQ_PEND, d);  chk("timer_pend_clr", d, 32'h0);
        chk("timer_irq_low", irq, 0);

        // Priority
        wb_write(IRQ_EN, 32'hFF);
        src = 8'h24;
        tick();
        src = 8'h00;
        tick();
        wb_read(IRQ_CLAIM, d); chk("prio_1", d, 32'd3);
        wb_read(IRQ_CLAIM, d); chk("prio_2", d, 32'd6);
        wb_read(IRQ_CLAIM, d); chk("prio_3", d, 32'd0);

        // Level vs edge on source 3
        wb_write(IRQ_TRIG, 32'hF7);
        src = 8'h08;
        tick();
        tick();
        wb_write(IRQ_PEND, 32'h08);
        wb_read(IRQ_PEND, d); chk("level_repend", d, 32'h08);
        wb_write(IRQ_TRIG, 32'hFF);
        wb_write(IRQ_PEND, 32'h08);
        wb_read(IRQ_PEND, d); chk("edge_cleared", d, 32'h00);
        src = 8'h00;
        idle(1);

        // W1C colliding with a new edge; then mask everything
        cyc = 1'b1; we = 1'b1; adr = IRQ_PEND; dat = 32'h02;
        tick();
        src = 8'h02;
        tick();
        we = 1'b0; cyc = 1'b0; src = 8'h00;
        wb_read(IRQ_PEND, d);  chk("collide_set", d, 32'h02);
        wb_write(IRQ_EN, 32'h0);
        wb_read(IRQ_CLAIM, d); chk("masked_claim", d, 32'd0);
        chk("masked_irq", irq, 0);
        wb_read(IRQ_PEND, d);  chk("masked_pend", d, 32'h02);

        // Async reset during a bus cycle
        wb_write(IRQ_EN, 32'h02);
        idle(2);
        chk("pre_rst_irq", irq, 1);
        cyc = 1'b1; we = 1'b0; adr = IRQ_PEND;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ack", ack, 0);
        chk("arst_irq", irq, 0);
        chk("arst_pend", rdt, 32'h0);
        cyc = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        idle(1);

        // Randomized traffic against the model
        repeat (800) begin
            logic [3:0] ra;
            src = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
            cyc = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 2) == 0);
            ra  = 4'($urandom_range(0, 10));
            adr = (ra > 4'd7) ? IRQ_CLAIM : ra[2:0];
            dat = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
